// File: rtl/riscv_pkg.sv
// Shared core constants and PC-unit types.
package riscv_pkg;

    localparam int          XLEN                 = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_e;

    localparam int PC_STEP_32 = 4;
    localparam int PC_STEP_16 = 2;

endpackage

// File: rtl/pc_if.sv
// Fetch handshake between the PC unit (master) and instruction memory (slave).
interface pc_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pc_ready;
    logic            compressed;

    modport master (output pc, pc_valid, input pc_ready, compressed);
    modport slave  (input pc, pc_valid, output pc_ready, compressed);

endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority mux for the next PC: trap > redirect > halt > fire > hold.
module pc_next_sel #(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic            run_i,
    input  logic            halted_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    input  logic            pc_ready_i,
    input  logic            compressed_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            misaligned_o,
    output logic            cnt_en_o
);
    import riscv_pkg::*;

    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] step;

    assign trap_tgt  = trap_vec_i & ~XLEN'(3);
    assign redir_tgt = redirect_pc_i & ~XLEN'(1);
    assign step      = (C_EXT && compressed_i) ? XLEN'(PC_STEP_16) : XLEN'(PC_STEP_32);

    // Pick the next PC; only an un-overridden fire in RUN advances and counts.
    always_comb begin
        pc_next_o    = pc_i;
        misaligned_o = 1'b0;
        cnt_en_o     = 1'b0;
        if ((run_i || halted_i) && trap_valid_i) begin
            pc_next_o = trap_tgt;
        end else if (run_i && redirect_valid_i) begin
            // Without compressed support a halfword-aligned target cannot be fetched.
            if (!C_EXT && redir_tgt[1]) begin
                misaligned_o = 1'b1;
            end else begin
                pc_next_o = redir_tgt;
            end
        end else if (run_i && halt_i) begin
            pc_next_o = pc_i;
        end else if (run_i && pc_ready_i) begin
            pc_next_o = pc_i + step;
            cnt_en_o  = 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address FSM, reset vector, trap/redirect/halt handling
// and accepted-fetch counter.
//
// state | meaning
// BOOT  | out of reset, PC holds reset vector, no fetch request yet
// RUN   | pc_valid asserted, PC advances on each accepted fetch
// HALT  | WFI, no fetch request; trap or wake returns to RUN
module pc_unit #(
    parameter int              XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR_DEFAULT,
    parameter bit              C_EXT        = 1'b0,
    parameter int              CNT_W        = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    pc_if.master             imem,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_vec_i,
    input  logic             halt_i,
    input  logic             wake_i,
    output logic             misaligned_o,
    output logic [XLEN-1:0]  misaligned_addr_o,
    output logic [CNT_W-1:0] fetch_count_o
);
    import riscv_pkg::*;

    localparam logic [1:0] S_BOOT = PC_BOOT;
    localparam logic [1:0] S_RUN  = PC_RUN;
    localparam logic [1:0] S_HALT = PC_HALT;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_d;
    logic            cnt_en;
    logic            run, halted;

    assign run    = (state_q == S_RUN);
    assign halted = (state_q == S_HALT);

    pc_next_sel #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_sel (
        .run_i            (run),
        .halted_i         (halted),
        .pc_i             (pc_q),
        .trap_valid_i     (trap_valid_i),
        .trap_vec_i       (trap_vec_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .halt_i           (halt_i),
        .pc_ready_i       (imem.pc_ready),
        .compressed_i     (imem.compressed),
        .pc_next_o        (pc_d),
        .misaligned_o     (mis_d),
        .cnt_en_o         (cnt_en)
    );

    // Next-state logic; trap and redirect both outrank halt in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN:  if (!trap_valid_i && !redirect_valid_i && halt_i) state_d = S_HALT;
            S_HALT: if (trap_valid_i || wake_i) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // State, PC, misalignment report and fetch counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= S_BOOT;
            pc_q              <= RESET_VECTOR;
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= '0;
            fetch_count_o     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_o <= mis_d;
            if (mis_d) misaligned_addr_o <= redirect_pc_i;
            if (cnt_en) fetch_count_o <= fetch_count_o + CNT_W'(1);
        end
    end

    assign imem.pc       = pc_q;
    assign imem.pc_valid = run;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (C_EXT=0 and C_EXT=1) on shared stimulus,
// checked every cycle against a behavioural model plus literal expectations.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        comp = 1'b0;
    logic        redir_v = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        trap_v = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        halt = 1'b0;
    logic        wake = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_if #(.XLEN(32)) if0 ();
    pc_if #(.XLEN(32)) if1 ();
    assign if0.pc_ready   = ready;
    assign if0.compressed = comp;
    assign if1.pc_ready   = ready;
    assign if1.compressed = comp;

    logic        mis0, mis1;
    logic [31:0] mis_addr0, mis_addr1;
    logic [63:0] cnt0, cnt1;

    pc_unit #(.C_EXT(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .imem(if0),
        .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
        .trap_valid_i(trap_v), .trap_vec_i(trap_vec),
        .halt_i(halt), .wake_i(wake),
        .misaligned_o(mis0), .misaligned_addr_o(mis_addr0), .fetch_count_o(cnt0)
    );

    pc_unit #(.C_EXT(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .imem(if1),
        .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
        .trap_valid_i(trap_v), .trap_vec_i(trap_vec),
        .halt_i(halt), .wake_i(wake),
        .misaligned_o(mis1), .misaligned_addr_o(mis_addr1), .fetch_count_o(cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: mode 0 = booting, 1 = fetching, 2 = halted.
    int          m_mode[2];
    logic [31:0] m_pc[2];
    logic [63:0] m_cnt[2];
    logic        m_mis[2];
    logic [31:0] m_mis_addr[2];

    task automatic model_step(input int c);
        logic [31:0] t;
        m_mis[c] = 1'b0;
        if (m_mode[c] == 0) begin
            m_mode[c] = 1;
        end else if (m_mode[c] == 2) begin
            if (trap_v) begin
                m_pc[c] = {trap_vec[31:2], 2'b00};
                m_mode[c] = 1;
            end else if (wake) begin
                m_mode[c] = 1;
            end
        end else begin
            if (trap_v) begin
                m_pc[c] = {trap_vec[31:2], 2'b00};
            end else if (redir_v) begin
                t = {redir_pc[31:1], 1'b0};
                if (c == 0 && t[1]) begin
                    m_mis[c] = 1'b1;
                    m_mis_addr[c] = redir_pc;
                end else begin
                    m_pc[c] = t;
                end
            end else if (halt) begin
                m_mode[c] = 2;
            end else if (ready) begin
                m_pc[c] = m_pc[c] + ((c == 1 && comp) ? 32'd2 : 32'd4);
                m_cnt[c] = m_cnt[c] + 64'd1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_mode[c] = 0;
                m_pc[c] = 32'h8000_0000;
                m_cnt[c] = '0;
                m_mis[c] = 1'b0;
                m_mis_addr[c] = '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) model_step(c);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("d0.pc", {32'h0, if0.pc}, {32'h0, m_pc[0]});
            chk("d0.valid", {63'h0, if0.pc_valid}, {63'h0, m_mode[0] == 1});
            chk("d0.mis", {63'h0, mis0}, {63'h0, m_mis[0]});
            chk("d0.mis_addr", {32'h0, mis_addr0}, {32'h0, m_mis_addr[0]});
            chk("d0.cnt", cnt0, m_cnt[0]);
            chk("d1.pc", {32'h0, if1.pc}, {32'h0, m_pc[1]});
            chk("d1.valid", {63'h0, if1.pc_valid}, {63'h0, m_mode[1] == 1});
            chk("d1.mis", {63'h0, mis1}, {63'h0, m_mis[1]});
            chk("d1.mis_addr", {32'h0, mis_addr1}, {32'h0, m_mis_addr[1]});
            chk("d1.cnt", cnt1, m_cnt[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick(); tick();
        chk("rst.pc", {32'h0, if0.pc}, 64'h8000_0000);
        chk("rst.valid", {63'h0, if0.pc_valid}, 64'h0);
        chk("rst.cnt", cnt0, 64'h0);
        chk("rst.mis", {63'h0, mis0}, 64'h0);
        chk("rst.mis_addr", {32'h0, mis_addr0}, 64'h0);

        ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("boot.valid", {63'h0, if0.pc_valid}, 64'h0);
        tick();
        chk("run.valid", {63'h0, if0.pc_valid}, 64'h1);
        chk("run.pc0", {32'h0, if0.pc}, 64'h8000_0000);
        tick();
        chk("run.pc1", {32'h0, if0.pc}, 64'h8000_0004);
        tick();
        chk("run.pc2", {32'h0, if0.pc}, 64'h8000_0008);
        chk("run.cnt2", cnt0, 64'd2);

        ready = 1'b0;
        tick(); tick(); tick();
        chk("stall.pc", {32'h0, if0.pc}, 64'h8000_0008);
        chk("stall.cnt", cnt0, 64'd2);
        ready = 1'b1;
        tick();
        chk("resume.pc", {32'h0, if0.pc}, 64'h8000_000C);
        chk("resume.cnt", cnt0, 64'd3);

        ready = 1'b0;
        redir_v = 1'b1; redir_pc = 32'h8000_0100;
        trap_v = 1'b1;  trap_vec = 32'h8000_0200;
        tick();
        chk("trap.pc", {32'h0, if0.pc}, 64'h8000_0200);
        chk("trap.cnt", cnt0, 64'd3);

        trap_v = 1'b0;
        redir_pc = 32'h8000_0102;
        ready = 1'b1; comp = 1'b1;
        tick();
        chk("mis.flag", {63'h0, mis0}, 64'h1);
        chk("mis.addr", {32'h0, mis_addr0}, 64'h8000_0102);
        chk("mis.pc", {32'h0, if0.pc}, 64'h8000_0200);
        chk("cext.pc", {32'h0, if1.pc}, 64'h8000_0102);
        chk("cext.mis", {63'h0, mis1}, 64'h0);
        redir_v = 1'b0;
        tick();
        chk("mis.pulse", {63'h0, mis0}, 64'h0);
        chk("mis.held", {32'h0, mis_addr0}, 64'h8000_0102);
        chk("mis.next", {32'h0, if0.pc}, 64'h8000_0204);
        chk("cext.step2", {32'h0, if1.pc}, 64'h8000_0104);

        comp = 1'b0;
        halt = 1'b1;
        tick();
        chk("halt.valid", {63'h0, if0.pc_valid}, 64'h0);
        chk("halt.pc", {32'h0, if0.pc}, 64'h8000_0204);
        halt = 1'b0;
        redir_v = 1'b1; redir_pc = 32'h8000_0300;
        tick();
        chk("halt.redir_ign", {32'h0, if0.pc}, 64'h8000_0204);
        redir_v = 1'b0;
        wake = 1'b1;
        tick();
        wake = 1'b0;
        chk("wake.valid", {63'h0, if0.pc_valid}, 64'h1);
        chk("wake.pc", {32'h0, if0.pc}, 64'h8000_0204);

        ready = 1'b0;
        redir_v = 1'b1; redir_pc = 32'h8000_0400; halt = 1'b1;
        tick();
        chk("redir_halt.pc", {32'h0, if0.pc}, 64'h8000_0400);
        chk("redir_halt.valid", {63'h0, if0.pc_valid}, 64'h1);
        redir_v = 1'b0;
        tick();
        chk("halt2.valid", {63'h0, if0.pc_valid}, 64'h0);
        trap_v = 1'b1; trap_vec = 32'h8000_0503;
        redir_v = 1'b1; redir_pc = 32'h8000_0600;
        tick();
        chk("all3.pc", {32'h0, if0.pc}, 64'h8000_0500);
        chk("all3.valid", {63'h0, if0.pc_valid}, 64'h1);
        trap_v = 1'b0; halt = 1'b0;

        redir_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap.pre", {32'h0, if0.pc}, 64'hFFFF_FFFC);
        redir_v = 1'b0; ready = 1'b1;
        tick();
        chk("wrap.pc", {32'h0, if0.pc}, 64'h0);
        chk("wrap.cnt", cnt0, 64'd5);
        tick(); tick();
        chk("wrap.after", {32'h0, if0.pc}, 64'h8);

        #2 rst_n = 1'b0;
        #1;
        chk("arst.pc", {32'h0, if0.pc}, 64'h8000_0000);
        chk("arst.valid", {63'h0, if0.pc_valid}, 64'h0);
        chk("arst.cnt", cnt0, 64'h0);
        chk("arst.pc1", {32'h0, if1.pc}, 64'h8000_0000);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rerun.pc", {32'h0, if0.pc}, 64'h8000_0008);
        chk("rerun.cnt", cnt0, 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
